// File: rtl/console_pkg.sv
// Shared constants and state encoding for the text-console character-RAM write path.
package console_pkg;

    localparam int COLS_DEFAULT   = 80;
    localparam int ROWS_DEFAULT   = 60;
    localparam int ADDR_W_DEFAULT = 13;

    localparam logic [7:0] CH_BS      = 8'h08;
    localparam logic [7:0] CH_LF      = 8'h0A;
    localparam logic [7:0] CH_FF      = 8'h0C;
    localparam logic [7:0] CH_CR      = 8'h0D;
    localparam logic [7:0] CH_DEL     = 8'h7F;
    localparam logic [7:0] BLANK_CHAR = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        CLR_LINE,
        CLR_ALL
    } state_t;

    // 0x7F is neither printable nor a recognised control code, so it is dropped.
    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c != CH_DEL);
    endfunction

endpackage

// File: rtl/console_write_ctrl_if.sv
// Byte-stream input handshake and character-RAM write port of the console write controller.
interface console_write_ctrl_if #(
    parameter int ADDR_W = 13
);

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/console_clear_seq.sv
// Address sequencer for blank-fill sweeps; a start issues the first address in the same cycle.
module console_clear_seq #(
    parameter int ADDR_W    = 13,
    parameter int LEN_W     = 14,
    parameter int RESET_LEN = 4800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    output logic              issue,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    logic              active;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] base_q;

    // NOTE: every output of an always_comb gets a value on every path so no latch is inferred.
    always_comb begin
        issue = start || (active && (cnt != len_q));
        addr  = start ? base : base_q + cnt[ADDR_W-1:0];
        done  = active && !start && (cnt == len_q);
    end

    // Reset leaves a full-screen sweep armed so the RAM is blanked after every reset.
    // NOTE: sequential state uses non-blocking assignments so all branches see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b1;
            cnt    <= '0;
            len_q  <= LEN_W'(RESET_LEN);
            base_q <= '0;
        end else if (start) begin
            active <= 1'b1;
            base_q <= base;
            len_q  <= len;
            cnt    <= LEN_W'(1);
        end else if (active) begin
            if (cnt == len_q) active <= 1'b0;
            else              cnt    <= cnt + LEN_W'(1);
        end
    end

endmodule

// File: rtl/console_write_ctrl.sv
// Single write master of the console character RAM: cursor, character writes, clears, scrolling.
module console_write_ctrl
    import console_pkg::*;
#(
    parameter int         COLS   = COLS_DEFAULT,
    parameter int         ROWS   = ROWS_DEFAULT,
    parameter int         ADDR_W = ADDR_W_DEFAULT,
    parameter logic [7:0] BLANK  = BLANK_CHAR
) (
    input  logic                 clk,
    input  logic                 rst,
    console_write_ctrl_if.master bus,
    output logic [ADDR_W-1:0]    top_base,
    output logic [6:0]           cursor_col,
    output logic [5:0]           cursor_row,
    output logic                 busy
);

    localparam int                SCREEN        = ROWS * COLS;
    localparam int                LEN_W         = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] ROW_STEP      = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [6:0]        LAST_COL      = 7'(COLS - 1);
    localparam logic [5:0]        LAST_ROW      = 6'(ROWS - 1);

    state_t            state;
    logic [ADDR_W-1:0] row_base;
    logic              scroll_pend;

    logic              accept, printable, at_last_col, at_bottom, do_newline;
    logic [ADDR_W-1:0] row_base_nx, top_base_nx, cur_addr;
    logic              clr_start, clr_issue, clr_done;
    logic [ADDR_W-1:0] clr_base, clr_addr;
    logic [LEN_W-1:0]  clr_len;

    assign bus.in_ready = (state == IDLE) && !rst;
    assign busy         = (state != IDLE);

    always_comb begin
        accept      = bus.in_valid && (state == IDLE);
        printable   = is_printable(bus.in_data);
        at_last_col = (cursor_col == LAST_COL);
        at_bottom   = (cursor_row == LAST_ROW);
        row_base_nx = (row_base == LAST_ROW_BASE) ? '0 : row_base + ROW_STEP;
        top_base_nx = (top_base == LAST_ROW_BASE) ? '0 : top_base + ROW_STEP;
        cur_addr    = row_base + ADDR_W'(cursor_col);
        do_newline  = accept && ((bus.in_data == CH_LF) || (printable && at_last_col));
        clr_start   = 1'b0;
        clr_base    = '0;
        clr_len     = '0;
        // A wrapping printable occupies its own write cycle, so its line clear starts one cycle later.
        if (accept && (bus.in_data == CH_FF)) begin
            clr_start = 1'b1;
            clr_len   = LEN_W'(SCREEN);
        end else if (accept && (bus.in_data == CH_LF) && at_bottom) begin
            clr_start = 1'b1;
            clr_base  = row_base_nx;
            clr_len   = LEN_W'(COLS);
        end else if ((state == CLR_LINE) && scroll_pend) begin
            clr_start = 1'b1;
            clr_base  = row_base;
            clr_len   = LEN_W'(COLS);
        end
    end

    console_clear_seq #(
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .RESET_LEN (SCREEN)
    ) u_clear_seq (
        .clk   (clk),
        .rst   (rst),
        .start (clr_start),
        .base  (clr_base),
        .len   (clr_len),
        .issue (clr_issue),
        .addr  (clr_addr),
        .done  (clr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= CLR_ALL;
            cursor_col  <= '0;
            cursor_row  <= '0;
            top_base    <= '0;
            row_base    <= '0;
            scroll_pend <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            bus.wr_en <= clr_issue;
            if (clr_issue) begin
                bus.wr_addr <= clr_addr;
                bus.wr_data <= BLANK;
            end
            if (clr_done) state <= IDLE;
            if ((state == CLR_LINE) && scroll_pend) begin
                scroll_pend <= 1'b0;
                top_base    <= top_base_nx;
            end

            if (accept) begin
                if (bus.in_data == CH_FF) begin
                    cursor_col <= '0;
                    cursor_row <= '0;
                    top_base   <= '0;
                    row_base   <= '0;
                    state      <= CLR_ALL;
                end else if (bus.in_data == CH_CR) begin
                    cursor_col <= '0;
                end else if (bus.in_data == CH_BS) begin
                    if (cursor_col != '0) begin
                        cursor_col  <= cursor_col - 7'd1;
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= cur_addr - ADDR_W'(1);
                        bus.wr_data <= BLANK;
                    end
                end else if (printable) begin
                    bus.wr_en   <= 1'b1;
                    bus.wr_addr <= cur_addr;
                    bus.wr_data <= bus.in_data;
                    if (!at_last_col) cursor_col <= cursor_col + 7'd1;
                end

                if (do_newline) begin
                    cursor_col <= '0;
                    row_base   <= row_base_nx;
                    if (!at_bottom) begin
                        cursor_row <= cursor_row + 6'd1;
                    end else begin
                        state <= CLR_LINE;
                        if (printable) scroll_pend <= 1'b1;
                        else           top_base    <= top_base_nx;
                    end
                end
            end
        end
    end

endmodule
